// File: rtl/vip_bit_morph_pkg.sv
// vip_bit_morph_pkg: shared constants for the binary morphology stages
// (erosion/dilation). Holds counter widths for the default frame size,
// the structuring-element masks, the pipeline latency and small width helpers.
package vip_bit_morph_pkg;

    // Default frame geometry used by the morphology stages.
    localparam int unsigned DEF_IMG_HDISP = 640;
    localparam int unsigned DEF_IMG_VDISP = 480;

    // Counter widths for the default frame size. The counters saturate at the
    // limit itself, so they must be able to hold the value IMG_xDISP.
    localparam int COL_W = $clog2(DEF_IMG_HDISP + 1);
    localparam int ROW_W = $clog2(DEF_IMG_VDISP + 1);

    // Structuring elements, MSB = top-left (p11), LSB = bottom-right (p33).
    localparam logic [8:0] SE_SQUARE = 9'b111_111_111;
    localparam logic [8:0] SE_CROSS  = 9'b010_111_010;

    // Clocks from an accepted pixel to its result on post_img_Bit.
    localparam int MORPH_LAT = 2;

    // Width of a counter that must reach 'limit' inclusive.
    function automatic int cnt_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

    // Address width for a memory of 'depth' entries (at least one bit).
    function automatic int addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/vip_bit_line_buffer.sv
// vip_bit_line_buffer: 1-bit line memory, single clock. The read port is
// combinational from the current contents, so a read and a write to the same
// address in one cycle return the old value (read-before-write). Contents are
// deliberately not reset; the caller gates stale data by row position.
module vip_bit_line_buffer #(
    parameter int DEPTH = 640,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic          wr_data,
    output logic          rd_data
);

    logic mem [DEPTH];

    // Old value is presented during the write cycle.
    assign rd_data = mem[addr];

    // Write the new pixel at the clock edge that ends the access cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/vip_bit_dilation_detector.sv
// vip_bit_dilation_detector: streaming binary 3x3 dilation, 1 bit/pixel.
// Two internal line buffers supply the two rows above the current pixel, a
// 3x3 window register collects the neighbourhood and the output is the OR of
// the window under the structuring element, two clocks after the pixel.
// The output for input position (r,c) is the dilation centred at (r-1,c-1);
// everything outside the image (rows < 0, cols < 0, cols >= IMG_HDISP in the
// rows above) reads as 0.
//
// Build option: define BIT_DILATION_CROSS_EN for the 4-neighbour cross
// element (corner taps removed); default is the full 3x3 square.
//
// Stream handshake: a pixel is transferred when per_frame_href and
// per_frame_clken are both high in a cycle (no backpressure). The post_*
// control lines are the inputs delayed by MORPH_LAT clocks regardless of
// clken; post_img_Bit is valid where post_frame_href & post_frame_clken.
module vip_bit_dilation_detector
    import vip_bit_morph_pkg::*;
#(
    parameter logic [9:0] IMG_HDISP = 10'd640,
    parameter logic [9:0] IMG_VDISP = 10'd480
) (
    input  logic clk,
    input  logic rst_n,
    input  logic per_frame_vsync,
    input  logic per_frame_href,
    input  logic per_frame_clken,
    input  logic per_img_Bit,
    output logic post_frame_vsync,
    output logic post_frame_href,
    output logic post_frame_clken,
    output logic post_img_Bit
);

    localparam int H_CNT_W = cnt_width(32'(IMG_HDISP));
    localparam int V_CNT_W = cnt_width(32'(IMG_VDISP));
    localparam int LB_AW   = addr_width(32'(IMG_HDISP));
    localparam int LB_DEPTH = int'(IMG_HDISP);

    localparam logic [H_CNT_W-1:0] H_LIM   = H_CNT_W'(IMG_HDISP);
    localparam logic [V_CNT_W-1:0] V_LIM   = V_CNT_W'(IMG_VDISP);
    localparam logic [V_CNT_W-1:0] ROW_TWO = V_CNT_W'(2);

`ifdef BIT_DILATION_CROSS_EN
    // Top and bottom rows keep only the middle and right taps; the right tap
    // is still needed as the delay stage feeding the middle column.
    localparam logic [8:0] SE_MASK = SE_CROSS;
    localparam int         EDGE_W  = 2;
`else
    localparam logic [8:0] SE_MASK = SE_SQUARE;
    localparam int         EDGE_W  = 3;
`endif

    // ------------------------------------------------------------------
    // Input qualification and edge detection
    // ------------------------------------------------------------------
    logic accept;
    logic href_q;
    logic vsync_q;
    logic href_rise;
    logic href_fall;
    logic vsync_rise;

    assign accept     = per_frame_href & per_frame_clken;
    assign href_rise  = per_frame_href & ~href_q;
    assign href_fall  = ~per_frame_href & href_q;
    assign vsync_rise = per_frame_vsync & ~vsync_q;

    // Remember the previous href/vsync level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            href_q  <= per_frame_href;
            vsync_q <= per_frame_vsync;
        end
    end

    // ------------------------------------------------------------------
    // Column / row position
    // ------------------------------------------------------------------
    logic [H_CNT_W-1:0] col_q;
    logic [H_CNT_W-1:0] col_cur;
    logic [H_CNT_W-1:0] col_nxt;
    logic [V_CNT_W-1:0] row_q;
    logic [V_CNT_W-1:0] row_cur;
    logic [V_CNT_W-1:0] row_nxt;
    logic               in_line;

    // An href rising edge restarts the line before the first pixel is
    // addressed, so the first pixel of a line always lands on column 0.
    always_comb begin
        col_cur = href_rise ? '0 : col_q;
        col_nxt = col_cur;
        if (accept && (col_cur != H_LIM)) begin
            col_nxt = col_cur + H_CNT_W'(1);
        end
    end

    // Row advances when a line ends and restarts at each new frame.
    always_comb begin
        row_cur = vsync_rise ? '0 : row_q;
        row_nxt = row_q;
        if (vsync_rise) begin
            row_nxt = '0;
        end else if (href_fall && (row_q != V_LIM)) begin
            row_nxt = row_q + V_CNT_W'(1);
        end
    end

    assign in_line = (col_cur < H_LIM);

    // Saturating position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_nxt;
            row_q <= row_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: LB1 holds row r-1, LB2 holds row r-2
    // ------------------------------------------------------------------
    logic             lb_wr;
    logic [LB_AW-1:0] lb_addr;
    logic             lb1_rd;
    logic             lb2_rd;
    logic             up1;
    logic             up2;

    assign lb_wr   = accept & in_line;
    assign lb_addr = lb_addr_of(col_cur);

    function automatic logic [LB_AW-1:0] lb_addr_of(input logic [H_CNT_W-1:0] col);
        return col[LB_AW-1:0];
    endfunction

    vip_bit_line_buffer #(
        .DEPTH (LB_DEPTH),
        .AW    (LB_AW)
    ) u_lb1 (
        .clk     (clk),
        .wr_en   (lb_wr),
        .addr    (lb_addr),
        .wr_data (per_img_Bit),
        .rd_data (lb1_rd)
    );

    // LB2 takes the value LB1 is about to lose, shifting the column down a row.
    vip_bit_line_buffer #(
        .DEPTH (LB_DEPTH),
        .AW    (LB_AW)
    ) u_lb2 (
        .clk     (clk),
        .wr_en   (lb_wr),
        .addr    (lb_addr),
        .wr_data (lb1_rd),
        .rd_data (lb2_rd)
    );

    // Rows above the frame and columns past the line buffer read as 0; this
    // also hides line-buffer contents left over from a previous frame.
    assign up1 = lb1_rd & in_line & (row_cur != '0);
    assign up2 = lb2_rd & in_line & (row_cur >= ROW_TWO);

    // ------------------------------------------------------------------
    // Stage 1: 3x3 window (top = row r-2, mid = row r-1, bot = row r)
    // Bit 0 of each row is the newest column (c), the MSB the oldest.
    // ------------------------------------------------------------------
    logic [EDGE_W-1:0] top_q, top_base, top_nxt;
    logic [2:0]        mid_q, mid_base, mid_nxt;
    logic [EDGE_W-1:0] bot_q, bot_base, bot_nxt;

    // Clear on a new line (columns < 0 read 0), then shift in the new column.
    always_comb begin
        top_base = href_rise ? '0 : top_q;
        mid_base = href_rise ? '0 : mid_q;
        bot_base = href_rise ? '0 : bot_q;
        top_nxt  = top_base;
        mid_nxt  = mid_base;
        bot_nxt  = bot_base;
        if (accept) begin
            top_nxt = {top_base[EDGE_W-2:0], up2};
            mid_nxt = {mid_base[1:0], up1};
            bot_nxt = {bot_base[EDGE_W-2:0], per_img_Bit};
        end
    end

    // Window registers hold between accepted pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q <= '0;
            mid_q <= '0;
            bot_q <= '0;
        end else begin
            top_q <= top_nxt;
            mid_q <= mid_nxt;
            bot_q <= bot_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: OR under the structuring element, control delay line
    // ------------------------------------------------------------------
    logic [8:0] win;
    logic       hit;
    logic       bit_q;
    logic [2:0] ctl_q [MORPH_LAT];

    // Narrow edge rows zero-extend into the missing corner positions.
    assign win = {3'(top_q), mid_q, 3'(bot_q)};
    assign hit = |(win & SE_MASK);

    // Control lines delayed MORPH_LAT clocks, {vsync, href, clken}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MORPH_LAT; i++) begin
                ctl_q[i] <= '0;
            end
        end else begin
            ctl_q[0] <= {per_frame_vsync, per_frame_href, per_frame_clken};
            for (int i = 1; i < MORPH_LAT; i++) begin
                ctl_q[i] <= ctl_q[i-1];
            end
        end
    end

    // Result recomputed every clock; forced low outside an active line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= ctl_q[MORPH_LAT-2][1] & hit;
        end
    end

    assign post_frame_vsync = ctl_q[MORPH_LAT-1][2];
    assign post_frame_href  = ctl_q[MORPH_LAT-1][1];
    assign post_frame_clken = ctl_q[MORPH_LAT-1][0];
    assign post_img_Bit     = bit_q;

endmodule

// File: tb/tb_vip_bit_dilation_detector.sv
// tb_vip_bit_dilation_detector: self-checking bench for the binary dilation
// stage on an 8x8 image. A frame is described as a 2-D bit array plus
// per-row widths; the reference computes each output directly from the
// dilation rule (centre (r-1,c-1), zero padding outside the image and past
// the line-buffer depth in rows above) and the observed stream is compared
// pixel by pixel.
module tb_vip_bit_dilation_detector;

    localparam int H = 8;
    localparam int V = 8;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic per_frame_vsync = 1'b0;
    logic per_frame_href = 1'b0;
    logic per_frame_clken = 1'b0;
    logic per_img_Bit = 1'b0;
    logic post_frame_vsync;
    logic post_frame_href;
    logic post_frame_clken;
    logic post_img_Bit;

    always #5 clk = ~clk;

    vip_bit_dilation_detector #(
        .IMG_HDISP (10'd8),
        .IMG_VDISP (10'd8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_Bit      (per_img_Bit),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_Bit     (post_img_Bit)
    );

    // ------------------------------------------------------------------
    // Frame description, scoreboard, counters
    // ------------------------------------------------------------------
    bit         img [0:7][0:11];
    int         row_w [0:7];
    int         nrows;
    logic [0:0] exp_q[$];
    int         exp_r[$];
    int         exp_c[$];
    logic [0:0] got_q[$];
    bit         collect = 1'b0;
    int         gate_viol;
    int         n_tests = 0;
    int         n_fail = 0;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (collect) begin
            if (post_frame_href && post_frame_clken) begin
                got_q.push_back(post_img_Bit);
            end else if (!post_frame_href && post_img_Bit) begin
                gate_viol++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic bit src(input int rr, input int cc, input int cur);
        if (rr < 0 || cc < 0) return 1'b0;
        if (rr < cur && cc >= H) return 1'b0;
        return img[rr][cc];
    endfunction

    function automatic bit in_se(input int a, input int b);
`ifdef BIT_DILATION_CROSS_EN
        return (a == 0) || (b == 0);
`else
        return (a >= -1) && (b >= -1);
`endif
    endfunction

    task automatic build_expected();
        exp_q.delete();
        exp_r.delete();
        exp_c.delete();
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < row_w[r]; c++) begin
                bit e;
                e = 1'b0;
                for (int a = -1; a <= 1; a++) begin
                    for (int b = -1; b <= 1; b++) begin
                        if (in_se(a, b)) e |= src(r - 1 + a, c - 1 + b, r);
                    end
                end
                exp_q.push_back(e);
                exp_r.push_back(r);
                exp_c.push_back(c);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step(input logic v, input logic h, input logic b);
        @(posedge clk);
        #1;
        per_frame_vsync = v;
        per_frame_href  = h;
        per_frame_clken = h;
        per_img_Bit     = b;
    endtask

    task automatic clear_img();
        nrows = V;
        for (int r = 0; r < 8; r++) begin
            row_w[r] = H;
            for (int c = 0; c < 12; c++) img[r][c] = 1'b0;
        end
    endtask

    task automatic run_frame();
        build_expected();
        got_q.delete();
        gate_viol = 0;
        collect = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < row_w[r]; c++) step(1'b1, 1'b1, img[r][c]);
            step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
        repeat (3) step(1'b0, 1'b0, 1'b0);
        collect = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            @(negedge clk);
            n_tests++;
            if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d got %b exp 0000", i,
                         {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit});
            end
        end
        @(posedge clk);
        #1;
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        per_img_Bit     = 1'b0;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (post_frame_href !== (k == 2)) begin
                n_fail++;
                $display("FAIL href_latency clk %0d after href got %b exp %b", k, post_frame_href, (k == 2));
            end
        end
        repeat (5) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_pattern_frames();
        // 0: single 1 at (4,4); 1: all ones; 2: all zeros;
        // 3: row 7 ones (primes line buffers); 4: single 1 at (0,0).
        for (int f = 0; f < 5; f++) begin
            clear_img();
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    img[r][c] = (f == 0) ? (r == 4 && c == 4) :
                                (f == 1) ? 1'b1 :
                                (f == 3) ? (r == 7) :
                                (f == 4) ? (r == 0 && c == 0) : 1'b0;
                end
            end
            run_frame();
            n_tests++;
            if (got_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL pattern%0d_len got %0d exp %0d", f, got_q.size(), exp_q.size());
            end
            foreach (exp_q[i]) begin
                n_tests++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL pattern%0d_pix (%0d,%0d) got %b exp %b", f, exp_r[i], exp_c[i],
                             (i < got_q.size()) ? got_q[i] : 1'bx, exp_q[i]);
                end
            end
            n_tests++;
            if (gate_viol != 0) begin
                n_fail++;
                $display("FAIL pattern%0d_gate got %0d bits outside href exp 0", f, gate_viol);
            end
        end
    endtask

    task automatic test_long_line();
        clear_img();
        row_w[3] = 10;
        img[3][8] = 1'b1;
        img[3][9] = 1'b1;
        img[5][2] = 1'b1;
        run_frame();
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL long_line_len got %0d exp %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_tests++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL long_line_pix (%0d,%0d) got %b exp %b", exp_r[i], exp_c[i],
                         (i < got_q.size()) ? got_q[i] : 1'bx, exp_q[i]);
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            repeat (8) step(1'b1, 1'b1, 1'b1);
            step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
        repeat (3) step(1'b1, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset_outputs got %b exp 0000",
                     {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit});
        end
        repeat (3) step(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) step(1'b0, 1'b0, 1'b0);
        clear_img();
        img[1][1] = 1'b1;
        run_frame();
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL after_reset_len got %0d exp %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_tests++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL after_reset_pix (%0d,%0d) got %b exp %b", exp_r[i], exp_c[i],
                         (i < got_q.size()) ? got_q[i] : 1'bx, exp_q[i]);
            end
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 5; f++) begin
            int dens;
            clear_img();
            nrows = $urandom_range(3, 8);
            dens = $urandom_range(2, 8);
            for (int r = 0; r < 8; r++) begin
                row_w[r] = $urandom_range(8, 11);
                for (int c = 0; c < 12; c++) img[r][c] = ($urandom_range(0, dens) == 0);
            end
            run_frame();
            n_tests++;
            if (got_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL random%0d_len got %0d exp %0d", f, got_q.size(), exp_q.size());
            end
            foreach (exp_q[i]) begin
                n_tests++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random%0d_pix (%0d,%0d) got %b exp %b", f, exp_r[i], exp_c[i],
                             (i < got_q.size()) ? got_q[i] : 1'bx, exp_q[i]);
                end
            end
            n_tests++;
            if (gate_viol != 0) begin
                n_fail++;
                $display("FAIL random%0d_gate got %0d bits outside href exp 0", f, gate_viol);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and final report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_pattern_frames();
        test_long_line();
        test_mid_frame_reset();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Run-time bound.
    initial begin
        #500000;
        $display("FAIL timeout simulation did not complete got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
